// File: rtl/mdu_iter.sv
// Iterative RV32M/RV64M multiply-divide unit with valid/ready handshakes.
// Fixed-latency multiply, restoring divide, RISC-V corner-case results.
module mdu_iter #(
    parameter int XLEN     = 32,
    parameter int MUL_LAT  = 2,
    parameter int DIV_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      mode,
    input  logic [XLEN-1:0] num1,
    input  logic [XLEN-1:0] num2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ans,
    output logic [1:0]      error,
    output logic            busy
);

    localparam int N_DIV = XLEN / DIV_STEP;
    localparam int CNT_W = $clog2(N_DIV + MUL_LAT + 1) + 1;
    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            state_r, state_n_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [1:0]        op_r;
    logic [XLEN-1:0]   opa_r, opb_r, rem_r;
    logic              neg_q_r, neg_r_r;
    logic [XLEN-1:0]   ans_r;
    logic [1:0]        error_r;
    logic              out_valid_r, busy_r, idle_r;

    logic              accept_s, load_s;
    logic [XLEN-1:0]   result_s;
    logic [1:0]        err_s;
    logic              legal_s, ovf_s, div_sgn_s;
    logic [2*XLEN-1:0] wide_a_s, wide_b_s, prod_s;
    logic [XLEN-1:0]   mul_res_s, fix_res_s, quo_q_s, rem_q_s;
    logic [XLEN-1:0]   quo_nx_s, rem_nx_s;
    logic [XLEN:0]     trial_s;

    function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
        neg_if = neg ? (ZERO - v) : v;
    endfunction

    assign in_ready  = idle_r & ~rst;
    assign out_valid = out_valid_r;
    assign ans       = ans_r;
    assign error     = error_r;
    assign busy      = busy_r;

    assign accept_s  = in_valid & in_ready & ~flush;
    assign legal_s   = (mode[7:3] == 5'b01000);
    assign div_sgn_s = ~mode[0];
    assign ovf_s     = div_sgn_s & (num1 == MIN) & (num2 == ONES);

    // Full-width product from operands sign-extended according to the MUL variant
    always_comb begin
        wide_a_s  = {{XLEN{(op_r != 2'b11) & opa_r[XLEN-1]}}, opa_r};
        wide_b_s  = {{XLEN{~op_r[1] & opb_r[XLEN-1]}}, opb_r};
        prod_s    = wide_a_s * wide_b_s;
        mul_res_s = (op_r == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end

    // DIV_STEP restoring divide steps on the magnitudes held in opa_r/rem_r
    always_comb begin
        quo_nx_s = opa_r;
        rem_nx_s = rem_r;
        trial_s  = {(XLEN+1){1'b0}};
        for (int i = 0; i < DIV_STEP; i++) begin
            trial_s  = {rem_nx_s, quo_nx_s[XLEN-1]};
            quo_nx_s = {quo_nx_s[XLEN-2:0], 1'b0};
            if (trial_s >= {1'b0, opb_r}) begin
                trial_s     = trial_s - {1'b0, opb_r};
                quo_nx_s[0] = 1'b1;
            end else begin
                quo_nx_s[0] = 1'b0;
            end
            rem_nx_s = trial_s[XLEN-1:0];
        end
    end

    // Sign correction of quotient/remainder for truncating signed division
    always_comb begin
        quo_q_s   = neg_if(neg_q_r, opa_r);
        rem_q_s   = neg_if(neg_r_r, rem_r);
        fix_res_s = op_r[1] ? rem_q_s : quo_q_s;
    end

    // Next-state logic and the result to capture on entry to DONE
    always_comb begin
        state_n_s = state_r;
        load_s    = 1'b0;
        result_s  = ZERO;
        err_s     = 2'b00;
        if (flush) begin
            state_n_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (!legal_s) begin
                            state_n_s = DONE;
                            load_s    = 1'b1;
                            err_s     = 2'b11;
                        end else if (!mode[2]) begin
                            state_n_s = MUL;
                        end else if (num2 == ZERO) begin
                            state_n_s = DONE;
                            load_s    = 1'b1;
                            result_s  = mode[1] ? num1 : ONES;
                            err_s     = 2'b01;
                        end else if (ovf_s) begin
                            state_n_s = DONE;
                            load_s    = 1'b1;
                            result_s  = mode[1] ? ZERO : num1;
                        end else begin
                            state_n_s = DIV;
                        end
                    end else begin
                        state_n_s = IDLE;
                    end
                end
                MUL: begin
                    if (cnt_r == CNT_W'(MUL_LAT - 1)) begin
                        state_n_s = DONE;
                        load_s    = 1'b1;
                        result_s  = mul_res_s;
                    end else begin
                        state_n_s = MUL;
                    end
                end
                DIV: begin
                    if (cnt_r == CNT_W'(N_DIV - 1)) begin
                        state_n_s = FIX;
                    end else begin
                        state_n_s = DIV;
                    end
                end
                FIX: begin
                    state_n_s = DONE;
                    load_s    = 1'b1;
                    result_s  = fix_res_s;
                end
                DONE: begin
                    if (out_ready) begin
                        state_n_s = IDLE;
                    end else begin
                        state_n_s = DONE;
                    end
                end
                default: begin
                    state_n_s = IDLE;
                end
            endcase
        end
    end

    // State register and registered handshake/result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            idle_r      <= 1'b1;
            ans_r       <= ZERO;
            error_r     <= 2'b00;
        end else begin
            state_r     <= state_n_s;
            out_valid_r <= (state_n_s == DONE);
            busy_r      <= (state_n_s != IDLE);
            idle_r      <= (state_n_s == IDLE);
            if (load_s) begin
                ans_r   <= result_s;
                error_r <= err_s;
            end else if (state_n_s != DONE) begin
                ans_r   <= ZERO;
                error_r <= 2'b00;
            end
        end
    end

    // Operand capture, cycle counter and divider iteration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= 2'b00;
            opa_r   <= ZERO;
            opb_r   <= ZERO;
            rem_r   <= ZERO;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= mode[1:0];
            opa_r   <= neg_if(mode[2] & div_sgn_s & num1[XLEN-1], num1);
            opb_r   <= neg_if(mode[2] & div_sgn_s & num2[XLEN-1], num2);
            rem_r   <= ZERO;
            neg_q_r <= div_sgn_s & (num1[XLEN-1] ^ num2[XLEN-1]);
            neg_r_r <= div_sgn_s & num1[XLEN-1];
        end else if (state_r == MUL) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else if (state_r == DIV) begin
            cnt_r <= cnt_r + CNT_W'(1);
            opa_r <= quo_nx_s;
            rem_r <= rem_nx_s;
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed scoreboard bench for mdu_iter (XLEN=32, MUL_LAT=2, DIV_STEP=1).
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid, busy;
    logic [7:0]  mode;
    logic [31:0] num1, num2, ans;
    logic [1:0]  error;

    typedef struct {
        logic [31:0] ans;
        logic [1:0]  err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mdu_iter #(.XLEN(32), .MUL_LAT(2), .DIV_STEP(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .num1(num1), .num2(num2), .out_valid(out_valid), .out_ready(out_ready),
        .ans(ans), .error(error), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mode = m; num1 = a; num2 = b; in_valid = 1'b1;
        check("in_ready_at_accept", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; mode = 8'h00; num1 = ~a; num2 = ~b;
    endtask

    task automatic do_op(input string tag, input logic [7:0] m, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ea, input logic [1:0] ee,
                         input int el, input int hold);
        exp_t e;
        int   lat;
        e.ans = ea; e.err = ee; e.lat = el;
        sb.push_back(e);
        out_ready = (hold == 0);
        start_op(m, a, b);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_sb_nonempty"}, {63'd0, (sb.size() != 0)}, 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
        end else begin
            e = '{ans: 32'd0, err: 2'b00, lat: 0};
        end
        check({tag, "_ans"}, {32'd0, ans}, {32'd0, e.ans});
        check({tag, "_err"}, {62'd0, error}, {62'd0, e.err});
        check({tag, "_lat"}, 64'(lat), 64'(e.lat));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
            check({tag, "_hold_ans"}, {32'd0, ans}, {32'd0, e.ans});
            check({tag, "_hold_in_ready"}, {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_drain_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_drain_in_ready"}, {63'd0, in_ready}, 64'd1);
        check({tag, "_drain_err"}, {62'd0, error}, 64'd0);
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check(tag, {63'd0, seen}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        mode = 8'h00; num1 = 32'd0; num2 = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_ans", {32'd0, ans}, 64'd0);
        check("rst_error", {62'd0, error}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;

        // multiplies
        do_op("mulh_min_min", 8'h41, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2'b00, 3, 0);
        do_op("mul_7_m3",     8'h40, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 2'b00, 3, 0);
        do_op("mulhu_ff_ff",  8'h43, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2'b00, 3, 0);
        do_op("mulhsu_m1_ff", 8'h42, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 3, 0);
        do_op("mulh_m1_m1",   8'h41, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2'b00, 3, 0);

        // overflow and divide-by-zero shortcuts
        do_op("div_ovf",  8'h44, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2'b00, 1, 0);
        do_op("rem_ovf",  8'h46, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2'b00, 1, 0);
        do_op("divu_z",   8'h45, 32'd7,         32'd0,         32'hFFFF_FFFF, 2'b01, 1, 0);
        do_op("remu_z",   8'h47, 32'd7,         32'd0,         32'd7,         2'b01, 1, 0);
        do_op("div_z",    8'h44, 32'd5,         32'd0,         32'hFFFF_FFFF, 2'b01, 1, 0);
        do_op("rem_z",    8'h46, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 2'b01, 1, 0);

        // iterative divides
        do_op("div_m7_2",   8'h44, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 2'b00, 34, 0);
        do_op("rem_m7_2",   8'h46, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 2'b00, 34, 0);
        do_op("divu_100_7", 8'h45, 32'd100,       32'd7,         32'd14,        2'b00, 34, 0);
        do_op("remu_100_7", 8'h47, 32'd100,       32'd7,         32'd2,         2'b00, 34, 0);
        do_op("div_7_m2",   8'h44, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 2'b00, 34, 0);
        do_op("rem_7_m2",   8'h46, 32'd7,         32'hFFFF_FFFE, 32'd1,         2'b00, 34, 0);
        do_op("divu_max_1", 8'h45, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 2'b00, 34, 0);
        do_op("div_min_1",  8'h44, 32'h8000_0000, 32'd1,         32'h8000_0000, 2'b00, 34, 0);

        // back-pressure in DONE
        do_op("hold_divu", 8'h45, 32'd100, 32'd7, 32'd14, 2'b00, 34, 5);

        // illegal modes
        do_op("illegal_30", 8'h30, 32'd9, 32'd3, 32'd0, 2'b11, 1, 0);
        do_op("illegal_48", 8'h48, 32'd9, 32'd3, 32'd0, 2'b11, 1, 0);

        // flush at T+10 of a divide
        start_op(8'h44, 32'hFFFF_FFF9, 32'd2);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        watch_quiet("flush_no_valid", 40);

        // flush together with in_valid in IDLE is not an accept
        @(negedge clk);
        mode = 8'h45; num1 = 32'd100; num2 = 32'd7; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_idle_busy", {63'd0, busy}, 64'd0);
        watch_quiet("flush_idle_no_valid", 40);

        // reset in the middle of a multiply
        start_op(8'h41, 32'h8000_0000, 32'h8000_0000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_busy", {63'd0, busy}, 64'd0);
        check("rstmid_valid", {63'd0, out_valid}, 64'd0);
        check("rstmid_ans", {32'd0, ans}, 64'd0);
        check("rstmid_in_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;
        #1;
        check("rstmid_in_ready_after", {63'd0, in_ready}, 64'd1);
        watch_quiet("rstmid_no_valid", 8);

        // unit still works after abort paths
        do_op("post_mulh", 8'h41, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2'b00, 3, 0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
